// File: rtl/sequential_divider_if.sv
// Operand/result handshake bundle shared by the sequential divider and its producer/consumer.
// The master side drives operands and dest_ready. The slave side (the divider) drives results and src_ready.
interface sequential_divider_if #(
    parameter int DIV_WIDTH = 16
);
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 src_valid;
    logic                 src_ready;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 div_by_zero;
    logic                 dest_valid;
    logic                 dest_ready;

    modport master (
        output dividend, divisor, src_valid, dest_ready,
        input  src_ready, quotient, remainder, div_by_zero, dest_valid
    );

    modport slave (
        input  dividend, divisor, src_valid, dest_ready,
        output src_ready, quotient, remainder, div_by_zero, dest_valid
    );
endinterface

// File: rtl/sequential_divider.sv
// Signed restoring divider that produces one quotient bit per cycle, with a valid/ready handshake on both sides.
// Defining DIV_ZERO_FAST_EN makes a zero divisor skip the iterations and finish on the first BUSY edge.
module sequential_divider #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sequential_divider_if.slave   bus
);
    localparam int CNT_W = $clog2(DIV_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     iter_cnt;
    logic                 sign_dvd;
    logic                 sign_dsr;
    // Unsigned W-bit magnitudes still hold |-2^(W-1)|. The dividend register also collects the quotient bits.
    logic [DIV_WIDTH-1:0] dvd_q;
    logic [DIV_WIDTH-1:0] dsr_q;
    logic [DIV_WIDTH:0]   prem_q;

    // NOTE: the datapath uses continuous assigns only. With no procedural combinational block, no latch can be inferred.
    logic [DIV_WIDTH+1:0] shifted;
    logic [DIV_WIDTH+1:0] trial;
    logic                 q_bit;
    logic [DIV_WIDTH:0]   prem_next;
    logic [DIV_WIDTH-1:0] quo_mag_next;
    logic [DIV_WIDTH-1:0] quo_signed;
    logic [DIV_WIDTH-1:0] rem_signed;
    logic                 dsr_zero;

    assign shifted      = {prem_q, dvd_q[DIV_WIDTH-1]};
    assign trial        = shifted - {2'b00, dsr_q};
    assign q_bit        = ~trial[DIV_WIDTH+1];
    assign prem_next    = q_bit ? trial[DIV_WIDTH:0] : shifted[DIV_WIDTH:0];
    assign quo_mag_next = {dvd_q[DIV_WIDTH-2:0], q_bit};
    assign quo_signed   = (sign_dvd ^ sign_dsr) ? -quo_mag_next : quo_mag_next;
    assign rem_signed   = sign_dvd ? -prem_next[DIV_WIDTH-1:0] : prem_next[DIV_WIDTH-1:0];
    assign dsr_zero     = (dsr_q == '0);

    // NOTE: every register is reset, including the datapath, so an aborted division leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            iter_cnt        <= '0;
            sign_dvd        <= 1'b0;
            sign_dsr        <= 1'b0;
            dvd_q           <= '0;
            dsr_q           <= '0;
            prem_q          <= '0;
            bus.src_ready   <= 1'b1;
            bus.dest_valid  <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.src_valid) begin
                        sign_dvd      <= bus.dividend[DIV_WIDTH-1];
                        sign_dsr      <= bus.divisor[DIV_WIDTH-1];
                        dvd_q         <= bus.dividend[DIV_WIDTH-1] ? -bus.dividend : bus.dividend;
                        dsr_q         <= bus.divisor[DIV_WIDTH-1] ? -bus.divisor : bus.divisor;
                        prem_q        <= '0;
                        iter_cnt      <= '0;
                        bus.src_ready <= 1'b0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
`ifdef DIV_ZERO_FAST_EN
                    if (dsr_zero) begin
                        // dvd_q is still untouched on the first BUSY edge, so it restores the dividend directly.
                        bus.quotient    <= '1;
                        bus.remainder   <= sign_dvd ? -dvd_q : dvd_q;
                        bus.div_by_zero <= 1'b1;
                        bus.dest_valid  <= 1'b1;
                        state           <= DONE;
                    end else begin
`else
                    begin
`endif
                        prem_q   <= prem_next;
                        dvd_q    <= quo_mag_next;
                        iter_cnt <= iter_cnt + 1'b1;
                        if (iter_cnt == LAST_ITER) begin
                            // A zero divisor accepts every trial, so the remainder naturally equals the dividend.
                            bus.quotient    <= dsr_zero ? '1 : quo_signed;
                            bus.remainder   <= rem_signed;
                            bus.div_by_zero <= dsr_zero;
                            bus.dest_valid  <= 1'b1;
                            state           <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.dest_ready) begin
                        bus.dest_valid  <= 1'b0;
                        bus.src_ready   <= 1'b1;
                        bus.div_by_zero <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed sign/boundary/handshake cases, then random operands.
// The reference model uses the simulator's own signed division.
module tb_sequential_divider;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    sequential_divider_if #(.DIV_WIDTH(W)) bus ();

    sequential_divider #(.DIV_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Truncating signed division: the quotient rounds toward zero and the remainder follows the dividend.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = W'(ai / bi);
            r  = W'(ai % bi);
            dz = 1'b0;
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        while (!bus.src_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        bus.dividend  = a;
        bus.divisor   = b;
        bus.src_valid = 1'b1;
        @(posedge clk); #1;
        bus.src_valid = 1'b0;
        bus.dividend  = W'($urandom);
        bus.divisor   = W'($urandom);
        check("busy_src_ready", 32'(bus.src_ready), 32'd0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.dest_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_result();
        bus.dest_ready = 1'b1;
        @(posedge clk); #1;
        bus.dest_ready = 1'b0;
        check("post_hs_dest_valid", 32'(bus.dest_valid), 32'd0);
        check("post_hs_src_ready", 32'(bus.src_ready), 32'd1);
        check("post_hs_dbz", 32'(bus.div_by_zero), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ed;
        int           n;
        int           lat;
        lat = W;
`ifdef DIV_ZERO_FAST_EN
        if (b == '0) lat = 1;
`endif
        model(a, b, eq, er, ed);
        start_op(a, b);
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ed));
        release_result();
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ed;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           n;

        bus.dividend   = '0;
        bus.divisor    = '0;
        bus.src_valid  = 1'b0;
        bus.dest_ready = 1'b0;

        #12;
        check("rst_src_ready", 32'(bus.src_ready), 32'd1);
        check("rst_dest_valid", 32'(bus.dest_valid), 32'd0);
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(16'd7, 16'd2, "pos_7_2");
        run_op(-16'sd7, 16'd2, "neg_7_2");
        run_op(16'd7, -16'sd2, "7_neg_2");
        run_op(-16'sd7, -16'sd2, "neg_7_neg_2");
        run_op(16'h8000, 16'hFFFF, "min_div_neg1");
        run_op(16'h8000, 16'd1, "min_div_1");
        run_op(16'd5, 16'd7, "small_5_7");
        run_op(16'd100, 16'd0, "div_zero_100");
        run_op(-16'sd100, 16'd0, "div_zero_neg100");

        // Backpressure: hold the result while a competing request waits.
        model(16'd1234, -16'sd56, eq, er, ed);
        start_op(16'd1234, -16'sd56);
        wait_done(n);
        check("bp_latency", 32'(n), 32'(W));
        bus.dividend  = 16'd111;
        bus.divisor   = 16'd3;
        bus.src_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_dest_valid", 32'(bus.dest_valid), 32'd1);
            check("bp_src_ready", 32'(bus.src_ready), 32'd0);
            check("bp_quotient", 32'(bus.quotient), 32'(eq));
            check("bp_remainder", 32'(bus.remainder), 32'(er));
        end
        release_result();
        bus.src_valid = 1'b0;

        // Abort a division partway through the iterations.
        start_op(16'd1000, 16'd7);
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_src_ready", 32'(bus.src_ready), 32'd1);
        check("abort_dest_valid", 32'(bus.dest_valid), 32'd0);
        check("abort_quotient", 32'(bus.quotient), 32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_result", 32'(bus.dest_valid), 32'd0);
        run_op(16'd20, 16'd3, "after_abort_20_3");

        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = '1;
                2: a = 16'h8000;
                3: b = W'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(a, b, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
